// File: rtl/io_input_port.sv
// Memory-mapped input peripheral: synchronised/debounced switches and keys,
// sticky key-press flags, a free-running cycle counter and an ID register.
module io_input_port #(
    parameter logic [31:0] IO_BASE   = 32'h0000_D000,
    parameter logic [31:0] IO_MASK   = 32'hFFFF_F000,
    parameter int unsigned DB_CYCLES = 270000,
    parameter int unsigned DB_W      = 19,
    parameter logic [31:0] ID_VALUE  = 32'h1000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_bwe,
    output logic        io_sel,
    output logic [31:0] io_rdata,
    output logic        io_rvalid
);

    localparam int unsigned SW_W  = 18;
    localparam int unsigned KEY_W = 4;
    localparam int unsigned IN_W  = SW_W + KEY_W;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [IN_W-1:0]  sync1;
    logic [IN_W-1:0]  sync2;
    logic [IN_W-1:0]  sync_val;
    logic [IN_W-1:0]  db_val;
    logic [DB_W-1:0]  db_cnt [IN_W];
    logic [SW_W-1:0]  sw_db;
    logic [KEY_W-1:0] key_db;
    logic [KEY_W-1:0] key_prev;
    logic [KEY_W-1:0] edge_flags;
    logic [KEY_W-1:0] edge_clr;
    logic [31:0]      cycles;
    logic [31:0]      cycles_wr;
    logic             in_map;
    logic             wr_en;
    logic [31:0]      rd_data;
    logic             unused_addr;

    assign io_sel      = (io_addr & IO_MASK) == IO_BASE;
    assign in_map      = io_addr[11:5] == 7'd0;
    assign wr_en       = io_sel && in_map && (|io_bwe);
    assign unused_addr = ^io_addr[1:0];

    // Keys are active-low on the board; invert once synchronised so 1 = pressed.
    assign sync_val = {sync2[IN_W-1:KEY_W], ~sync2[KEY_W-1:0]};
    assign sw_db    = db_val[IN_W-1:KEY_W];
    assign key_db   = db_val[KEY_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {SW, KEY};
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: a bit only follows its input after DB_CYCLES stable cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_val <= '0;
            for (int i = 0; i < int'(IN_W); i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(IN_W); i++) begin
                if (sync_val[i] == db_val[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_val[i] <= sync_val[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        edge_clr = '0;
        if (wr_en && io_addr[4:2] == 3'd2 && io_bwe[0]) edge_clr = io_wdata[KEY_W-1:0];
    end

    // Applying the rise after the clear makes a simultaneous set win.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev   <= '0;
            edge_flags <= '0;
        end else begin
            key_prev   <= key_db;
            edge_flags <= (edge_flags & ~edge_clr) | (key_db & ~key_prev);
        end
    end

    always_comb begin
        cycles_wr = cycles;
        for (int b = 0; b < 4; b++) begin
            if (io_bwe[b]) cycles_wr[8*b +: 8] = io_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles <= '0;
        end else if (wr_en && io_addr[4:2] == 3'd3) begin
            cycles <= cycles_wr;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (io_addr[4:2])
            3'd0:    rd_data = {14'd0, sw_db};
            3'd1:    rd_data = {28'd0, key_db};
            3'd2:    rd_data = {28'd0, edge_flags};
            3'd3:    rd_data = cycles;
            3'd4:    rd_data = ID_VALUE;
            default: rd_data = '0;
        endcase
    end

    // Read data is sampled before this cycle's write lands, matching SRAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata  <= '0;
            io_rvalid <= 1'b0;
        end else begin
            io_rdata  <= (io_sel && in_map) ? rd_data : 32'd0;
            io_rvalid <= io_sel;
        end
    end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Memory-mapped input peripheral on the processor data bus; the read side of the IO space, complementing the write-only video IO path.
- Synchronises and debounces SW[17:0] and KEY[3:0], captures key presses in sticky flags, and keeps a free-running cycle counter.
- Returns registered read data with the same 1-cycle latency as the synchronous SRAM.
- The top level uses io_rvalid to steer processor DataIn between io_rdata and memory data.

Parameters:
IO_BASE, 32'h0000_D000, base address of the 4 KB input window.
IO_MASK, 32'hFFFF_F000, address bits compared against IO_BASE.
DB_CYCLES, 270000, stable cycles required before a debounced input changes (10 ms at 27 MHz).
DB_W, 19, width of each debounce counter (must hold DB_CYCLES).
ID_VALUE, 32'h1000_0001, constant returned by the ID register.

Ports:
clk  in  1  system clock (27 MHz)
rst  in  1  synchronous, active-high reset
SW  in  18  raw toggle switches, asynchronous
KEY  in  4  raw pushbuttons, active-low, asynchronous
io_addr  in  32  processor data byte address
io_wdata  in  32  processor store data
io_bwe  in  4  processor byte write enables
io_sel  out  1  combinational: (io_addr & IO_MASK) == IO_BASE
io_rdata  out  32  registered read data
io_rvalid  out  1  io_sel registered one cycle; top-level mux select

Behaviour:
- Register map (word offset io_addr[4:2]; io_addr[11:5] must be 0, else reads return 0):
  - 0 SW: {14'b0, sw_db}. Read-only.
  - 1 KEYLVL: {28'b0, key_db}, with 1 = pressed. Read-only.
  - 2 KEYEDGE: {28'b0, edge}, sticky. Write-1-to-clear on bits [3:0] when io_bwe[0]=1.
  - 3 CYCLES: 32-bit counter, increments every cycle. Writable per byte lane; a written lane takes io_wdata for that lane. There is no increment in the write cycle, so a written value V reads back V+k after k cycles.
  - 4 ID: ID_VALUE. Read-only.
  - 5-7: read 0; writes ignored.
- Writes take effect only when io_sel=1 and |io_bwe=1. Writes to read-only registers are ignored.
- Input synchronisation: two flip-flop stages per bit. KEY is inverted after synchronisation.
- Debounce, per bit:
  - When the synchronised value equals the debounced value, the counter holds 0.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1, the debounced bit takes the synchronised value and the counter clears.
  - A bounce back to the debounced value before that point clears the counter.
  - Latency from a raw change to the debounced change is 2 + DB_CYCLES cycles.
- Edge capture:
  - A flag bit sets on the cycle after key_db[i] rises 0→1.
  - If a set and a W1C clear hit the same bit in the same cycle, set wins (bit = 1).
  - Key releases never set a flag.
- Read path:
  - io_rdata and io_rvalid register every cycle from the current io_addr/io_sel. A read issued in cycle N is valid in cycle N+1.
  - io_rdata shows register state before any write in cycle N (read-before-write).
  - io_rdata = 0 whenever the previous-cycle io_sel was 0.
- Reset (synchronous, rst=1 sampled on a clk edge) clears:
  - sync stages, sw_db, key_db (not pressed), all debounce counters
  - edge = 0, CYCLES = 0, io_rdata = 0, io_rvalid = 0
  - Reset asserted mid-debounce discards the partial count; debounce restarts after rst falls.
- Wrap: CYCLES rolls over from 32'hFFFF_FFFF to 0 with no flag. Debounce counters cannot overflow.

Test Plan (DB_CYCLES=4):
- Reset: hold rst 2 cycles with SW=18'h3FFFF and KEY=4'h0. Require io_rvalid=0, io_rdata=0, and a read of 0xD000 returning 0 until 6 cycles after rst falls, then 32'h0003_FFFF. A read of 0xD010 in cycle N returns 32'h1000_0001 in N+1.
- Debounce: toggle SW[0] high 2 cycles, low 1 cycle, then high steadily. Require sw_db[0] to change only 6 cycles after the last edge. The glitch must never be reported.
- Edge capture and W1C: press KEY[2] (drive 0) steadily. Require KEYLVL=4'h4, then KEYEDGE=4'h4. Write 32'h4 to 0xD008 with io_bwe=4'h1; next read gives 0. Issue a clear in the same cycle as a new key_db rise; the bit reads 1.
- Counter write: write 32'hFFFF_FFFE to 0xD00C with io_bwe=4'hF in cycle N. A read at N+1 returns FFFF_FFFE; a read at N+3 returns 0000_0000 (wrap). Write byte lane 1 only (io_bwe=4'h2) with 32'h0000_AB00; require only bits[15:8]=AB to change.
- Decode and mux: read 0xD01C returns 0. Read 0xE000 gives io_sel=0, io_rvalid=0 next cycle, io_rdata=0. Alternate 0xD010/0x0100 every cycle and check io_rvalid toggles with 1-cycle lag. Write to 0xD000 and confirm SW is unchanged.
